// File: rtl/lut_page_loader.sv
// Fill sequencer for the dual-bank LUT page memory: packs BANK_INTERLEAVE words per page,
// writes pages 0..PAGE_NUM-1 in order, then raises lut_valid_o.
module lut_page_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int PAGE_NUM        = 16,
  parameter int BANK_INTERLEAVE = 2,
  parameter int ADDR_BITWIDTH   = 4
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [QUAN_SIZE-1:0]                 word_i,
  input  logic                                 word_valid_i,
  output logic                                 word_ready_o,
  output logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] write_data_o,
  output logic [ADDR_BITWIDTH-1:0]             write_addr_o,
  output logic                                 we_o,
  output logic                                 lut_valid_o,
  output logic                                 load_done_o,
  output logic                                 busy_o
);

  localparam int PAGE_W = QUAN_SIZE * BANK_INTERLEAVE;
  localparam int IDX_W  = $clog2(BANK_INTERLEAVE);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_t;

  state_t                   state_q;
  logic [ADDR_BITWIDTH-1:0] page_cnt_q;
  logic [IDX_W-1:0]         word_idx_q;
  logic [PAGE_W-1:0]        page_q;
  logic [PAGE_W-1:0]        page_d;
  logic [PAGE_W-1:0]        write_data_q;
  logic [ADDR_BITWIDTH-1:0] write_addr_q;
  logic                     we_q;
  logic                     lut_valid_q;
  logic                     load_done_q;
  logic                     busy_q;
  logic                     hs;
  logic                     last_word;
  logic                     last_page;

  assign word_ready_o = (state_q == FILL);
  assign hs           = word_valid_i & word_ready_o;
  assign last_word    = (word_idx_q == IDX_W'(BANK_INTERLEAVE - 1));
  assign last_page    = (page_cnt_q == ADDR_BITWIDTH'(PAGE_NUM - 1));

  // First word of a page lands in the MSBs so bank-select 0 reads it back.
  always_comb begin
    page_d = page_q;
    for (int k = 0; k < BANK_INTERLEAVE; k++) begin
      if (word_idx_q == IDX_W'(k)) begin
        page_d[(BANK_INTERLEAVE-k)*QUAN_SIZE-1 -: QUAN_SIZE] = word_i;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      page_cnt_q   <= '0;
      word_idx_q   <= '0;
      page_q       <= '0;
      write_data_q <= '0;
      write_addr_q <= '0;
      we_q         <= 1'b0;
      lut_valid_q  <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q     <= FILL;
            page_cnt_q  <= '0;
            word_idx_q  <= '0;
            page_q      <= '0;
            lut_valid_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        FILL: begin
          if (hs) begin
            page_q <= page_d;
            if (last_word) begin
              word_idx_q   <= '0;
              write_data_q <= page_d;
              write_addr_q <= page_cnt_q;
              we_q         <= 1'b1;
              state_q      <= COMMIT;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          we_q <= 1'b0;
          if (last_page) begin
            state_q     <= DONE;
            lut_valid_q <= 1'b1;
            load_done_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            page_cnt_q <= page_cnt_q + 1'b1;
            state_q    <= FILL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign write_data_o = write_data_q;
  assign write_addr_o = write_addr_q;
  assign we_o         = we_q;
  assign lut_valid_o  = lut_valid_q;
  assign load_done_o  = load_done_q;
  assign busy_o       = busy_q;

endmodule
